uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised UART transmit path: a synchronous FIFO feeding a frame serialiser with runtime-selectable data width, parity and stop-bit count, and CTS flow control. It is the next generation of the fixed-format transmitter in the UART interface. It sits between the testbench or host write side (`Wr_En`/`Wr_Data`) and the board `Tx` pin. Frame format is latched per frame, so software may reconfigure without corrupting a frame in flight.

## Interface
Parameters:
- `SYSCLK_RATE`, 100000000 — clock frequency, Hz.
- `BAUD_RATE`, 9600 — line rate. Bit time is `DIV = SYSCLK_RATE / BAUD_RATE` (integer truncation), and `DIV` must be ≥ 2.
- `MAX_DATA_BITS`, 9 — width of `Wr_Data` and of each FIFO entry; legal range 5..9.
- `FIFO_DEPTH`, 8 — number of entries; must be a power of two, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `SysClk` in 1 — system clock, rising edge.
- `Rst` in 1 — synchronous, active-high reset.
- `Wr_En` in 1 — push `Wr_Data` into the FIFO this cycle.
- `Wr_Data` in `MAX_DATA_BITS` — character, LSB-aligned.
- `Cfg_Data_Bits` in 4 — data bits per frame.
- `Cfg_Parity` in 2 — 0 = none, 1 = even, 2 = odd, 3 = none.
- `Cfg_Stop_Bits` in 1 — 0 = one stop bit, 1 = two stop bits.
- `CTS` in 1 — 1 = remote ready; a frame may start.
- `Clr_Overflow` in 1 — clears `FIFO_Overflow`.
- `Tx` out 1 — serial line, idle high.
- `Tx_Busy` out 1 — a frame is on the line.
- `FIFO_Empty` out 1, `FIFO_Full` out 1 — FIFO status flags.
- `FIFO_Overflow` out 1 — sticky; set when a write is dropped.
- `Fill_Level` out `$clog2(FIFO_DEPTH+1)` — number of entries held.

## Operation
- **Reset values:** `Tx`=1, `Tx_Busy`=0, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, `Fill_Level`=0, FSM in IDLE. Reset mid-frame aborts the frame and discards all FIFO contents.
- **Write:** `Wr_En` with `FIFO_Full`=0 stores the entry. `Wr_En` with `FIFO_Full`=1 drops the write and sets `FIFO_Overflow`, even if a pop occurs in the same cycle.
- **Overflow flag:** `Clr_Overflow` clears `FIFO_Overflow`. If a set and a clear occur in the same cycle, set wins.
- **Simultaneous push and pop (not full):** `Fill_Level` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **Configuration latch:** `Cfg_*` are captured at frame start and held for the whole frame.
- **Data-width clamping:** `Cfg_Data_Bits` < 5 is treated as 5; values > `MAX_DATA_BITS` are treated as `MAX_DATA_BITS`. `Wr_Data` bits at or above the effective width are ignored.
- **FSM states:**
  - IDLE: `Tx`=1. Go to START when `FIFO_Empty`=0 and `CTS`=1.
  - START: `Tx`=0 for one bit time.
  - DATA: D bits, LSB first.
  - PARITY: present only if parity is enabled.
  - STOP: `Tx`=1 for one or two bit times.
- **Frame start action:** entering START pops the FIFO, loads the shift register and latches the configuration.
- **Parity:** even parity bit = XOR of the D data bits; odd parity bit = its inverse.
- **Back-to-back frames:** at the end of the last stop bit, if `FIFO_Empty`=0 and `CTS`=1, the FSM goes straight to START with no idle cycle. Otherwise it goes to IDLE.
- **CTS:** sampled only at frame start. Deassertion mid-frame never truncates a frame.
- `Tx_Busy` = 1 in every state except IDLE.

## Timing
- The `Tx` line, the FIFO flags, `Fill_Level`, `Tx_Busy` and `FIFO_Overflow` are all registered.
- Write captured at edge k into an empty FIFO with the FSM idle and `CTS`=1:
  - `FIFO_Empty`=0 after edge k.
  - Pop occurs at edge k+1: `Tx`=0, `Tx_Busy`=1 and `FIFO_Empty`=1 after edge k+1.
- Each bit holds for exactly `DIV` cycles. The divider restarts at every frame start.
- Frame length is `(1 + D + P + S) × DIV` cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `FIFO_Full` and `FIFO_Empty` update on the edge that changes `Fill_Level`.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` (NONE, EVEN, ODD).
  - `tx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - Constant function `baud_div(SYSCLK_RATE, BAUD_RATE)`.
  - `MIN_DATA_BITS` = 5.
- Sub-module `uart_sync_fifo`, parameterised on width and depth. It provides write, pop, full/empty, level and overflow. The receive path will reuse it.
- Top level contains the serialiser FSM, the bit-time counter, the bit index and the config latch.

## Test plan
All scenarios use `SYSCLK_RATE`=100e6 and `BAUD_RATE`=10e6 (`DIV`=10), with `CTS`=1 unless stated.
- **8N1:** write 0xA5 with 8 data bits, no parity, one stop bit.
  - `Tx` low for 10 cycles, then bits 1,0,1,0,0,1,0,1, then high for 10 cycles.
  - Frame = 100 cycles; `Tx_Busy` high for exactly 100 cycles.
- **7E2 / 7O2:** 7 data bits, two stop bits, data 0x55.
  - Even parity: parity bit = 0. Odd parity: parity bit = 1.
  - Frame = 110 cycles.
  - Changing `Cfg_Parity` mid-frame does not alter the current frame.
- **Fill and overflow:** with `CTS`=0, write 9 bytes.
  - `FIFO_Full`=1 and `Fill_Level`=8 after the 8th write; the 9th write sets `FIFO_Overflow` and `Fill_Level` stays 8.
  - `Clr_Overflow` clears the flag.
  - Raising `CTS` drains all 8 bytes in write order.
- **Back-to-back:** write 3 bytes in consecutive cycles (8N1) → `Tx_Busy` continuously high for 300 cycles, with no idle gap between frames.
- **CTS mid-frame:** drop `CTS` during data bit 2 → the current frame completes; the next queued frame starts one cycle after `CTS` returns high.
- **Reset mid-frame:** assert `Rst` during data bit 3 → after that edge `Tx`=1, `FIFO_Empty`=1, `Fill_Level`=0, and no further `Tx` activity.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive paths.
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clock cycles per bit (integer truncation).
    function automatic int baud_div(input longint sysclk_rate, input longint baud_rate);
        return int'(sysclk_rate / baud_rate);
    endfunction

    // Encoding 3 is an alias for "no parity".
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return EVEN;
            2'd2:    return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and a sticky overflow flag.
// A write while full is dropped even if a pop happens on the same edge.
module uart_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_clr_overflow,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;

    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    // Next fill level; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + LW'(1);
        else if (w_pop && !w_push)
            w_level_nxt = r_level - LW'(1);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers, level, flags; flags derive from the next level so they move on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            // Set wins over clear.
            if (i_wr_en && r_full)
                r_overflow <= 1'b1;
            else if (i_clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;
    assign o_level    = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a frame serialiser with per-frame
// latched format (data width, parity, stop bits) and CTS gating at frame start.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE   = 100000000,
    parameter int BAUD_RATE     = 9600,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                             SysClk,
    input  logic                             Rst,
    input  logic                             Wr_En,
    input  logic [MAX_DATA_BITS-1:0]         Wr_Data,
    input  logic [3:0]                       Cfg_Data_Bits,
    input  logic [1:0]                       Cfg_Parity,
    input  logic                             Cfg_Stop_Bits,
    input  logic                             CTS,
    input  logic                             Clr_Overflow,
    output logic                             Tx,
    output logic                             Tx_Busy,
    output logic                             FIFO_Empty,
    output logic                             FIFO_Full,
    output logic                             FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  Fill_Level
);

    localparam int             DIV      = baud_div(SYSCLK_RATE, BAUD_RATE);
    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

    // Serialiser state
    tx_state_e                r_state;
    tx_state_e                w_state_nxt;
    logic                     r_tx;
    logic                     w_tx_nxt;
    logic                     r_busy;
    logic [CW-1:0]            r_div_cnt;
    logic [3:0]               r_bit_idx;
    logic [3:0]               w_idx_nxt;
    logic [MAX_DATA_BITS-1:0] r_shift;

    // Per-frame latched configuration
    logic [3:0]               r_dbits;
    logic                     r_par_en;
    logic                     r_par_bit;
    logic                     r_stop2;

    // Control / datapath wires
    logic                     w_start;
    logic                     w_shift;
    logic                     w_bit_end;
    logic                     w_can_start;
    logic [3:0]               w_eff_bits;
    logic [MAX_DATA_BITS-1:0] w_mask;
    logic [MAX_DATA_BITS-1:0] w_char;
    parity_e                  w_parity;
    logic                     w_fifo_empty;
    logic [MAX_DATA_BITS-1:0] w_fifo_data;

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk          (SysClk),
        .i_rst          (Rst),
        .i_wr_en        (Wr_En),
        .i_wr_data      (Wr_Data),
        .i_rd_en        (w_start),
        .i_clr_overflow (Clr_Overflow),
        .o_rd_data      (w_fifo_data),
        .o_full         (FIFO_Full),
        .o_empty        (w_fifo_empty),
        .o_overflow     (FIFO_Overflow),
        .o_level        (Fill_Level)
    );

    assign FIFO_Empty  = w_fifo_empty;
    assign w_bit_end   = (r_div_cnt == DIV_LAST);
    assign w_can_start = ~w_fifo_empty & CTS;
    assign w_parity    = decode_parity(Cfg_Parity);

    // Clamp requested width and mask off character bits beyond it.
    always_comb begin
        if (Cfg_Data_Bits < 4'(MIN_DATA_BITS))
            w_eff_bits = 4'(MIN_DATA_BITS);
        else if (Cfg_Data_Bits > 4'(MAX_DATA_BITS))
            w_eff_bits = 4'(MAX_DATA_BITS);
        else
            w_eff_bits = Cfg_Data_Bits;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            w_mask[i] = (i < int'(w_eff_bits));
        w_char = w_fifo_data & w_mask;
    end

    // Next state and next line level; Tx is registered so it is computed one edge ahead.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_idx_nxt   = r_bit_idx;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_can_start)
                    w_start = 1'b1;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = 4'd0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == r_dbits - 4'd1) begin
                        w_idx_nxt = 4'd0;
                        if (r_par_en) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        // Next bit is r_shift[1]; shift so it sits at [0] afterwards.
                        w_tx_nxt  = r_shift[1];
                        w_shift   = 1'b1;
                        w_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                    w_idx_nxt   = 4'd0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && r_bit_idx == 4'd0) begin
                        w_idx_nxt = 4'd1;
                    end else begin
                        // Last stop bit: chain straight into the next frame if allowed.
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                        w_idx_nxt   = 4'd0;
                        if (w_can_start)
                            w_start = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        if (w_start) begin
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
            w_idx_nxt   = 4'd0;
        end
    end

    // State, line, bit timer and frame-start latch of character and format.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_dbits   <= 4'(MIN_DATA_BITS);
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_bit_idx <= w_idx_nxt;
            if (w_start) begin
                r_div_cnt <= '0;
                r_shift   <= w_char;
                r_dbits   <= w_eff_bits;
                r_par_en  <= (w_parity != NONE);
                r_par_bit <= (^w_char) ^ (w_parity == ODD);
                r_stop2   <= Cfg_Stop_Bits;
            end else if (r_state != IDLE) begin
                r_div_cnt <= w_bit_end ? '0 : r_div_cnt + CW'(1);
                if (w_shift)
                    r_shift <= r_shift >> 1;
            end
        end
    end

    assign Tx      = r_tx;
    assign Tx_Busy = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised + directed bench for uart_tx_fifo against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int SYS   = 100000000;
    localparam int BAUD  = 10000000;
    localparam int DIV   = 10;
    localparam int MAXB  = 9;
    localparam int DEPTH = 8;

    logic            SysClk = 1'b0;
    logic            Rst = 1'b1;
    logic            Wr_En = 1'b0;
    logic [MAXB-1:0] Wr_Data = '0;
    logic [3:0]      Cfg_Data_Bits = 4'd8;
    logic [1:0]      Cfg_Parity = 2'd0;
    logic            Cfg_Stop_Bits = 1'b0;
    logic            CTS = 1'b1;
    logic            Clr_Overflow = 1'b0;
    logic            Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow;
    logic [3:0]      Fill_Level;

    uart_tx_fifo #(
        .SYSCLK_RATE   (SYS),
        .BAUD_RATE     (BAUD),
        .MAX_DATA_BITS (MAXB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Wr_En         (Wr_En),
        .Wr_Data       (Wr_Data),
        .Cfg_Data_Bits (Cfg_Data_Bits),
        .Cfg_Parity    (Cfg_Parity),
        .Cfg_Stop_Bits (Cfg_Stop_Bits),
        .CTS           (CTS),
        .Clr_Overflow  (Clr_Overflow),
        .Tx            (Tx),
        .Tx_Busy       (Tx_Busy),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .Fill_Level    (Fill_Level)
    );

    always #5 SysClk = ~SysClk;

    // Reference model: queue of characters, current frame as a list of line bits.
    int q[$];
    int m_bits[$];
    int m_pos;
    bit m_active;
    bit m_ovf;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Build the line-bit list for one frame from the current configuration.
    task automatic start_frame(input int ch);
        int d;
        int par;
        d = int'(Cfg_Data_Bits);
        if (d < 5) d = 5;
        if (d > MAXB) d = MAXB;
        par = 0;
        m_bits.delete();
        m_bits.push_back(0);
        for (int i = 0; i < d; i++) begin
            m_bits.push_back((ch >> i) & 1);
            par ^= (ch >> i) & 1;
        end
        if (Cfg_Parity == 2'd1) m_bits.push_back(par);
        if (Cfg_Parity == 2'd2) m_bits.push_back(par ^ 1);
        m_bits.push_back(1);
        if (Cfg_Stop_Bits) m_bits.push_back(1);
        m_pos    = 0;
        m_active = 1;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_step();
        bit full_pre;
        bit empty_pre;
        if (Rst) begin
            q.delete();
            m_active = 0;
            m_ovf    = 0;
            return;
        end
        full_pre  = (q.size() == DEPTH);
        empty_pre = (q.size() == 0);
        if (m_active) begin
            m_pos++;
            if (m_pos == m_bits.size() * DIV) m_active = 0;
        end
        if (!m_active && !empty_pre && CTS) start_frame(q.pop_front());
        if (Wr_En && !full_pre) q.push_back(int'(Wr_Data));
        if (Wr_En && full_pre) m_ovf = 1;
        else if (Clr_Overflow) m_ovf = 0;
    endtask

    task automatic tick();
        int exp_tx;
        @(posedge SysClk);
        model_step();
        #1;
        exp_tx = m_active ? m_bits[m_pos / DIV] : 1;
        chk("tx",    32'(Tx),            32'(exp_tx));
        chk("busy",  32'(Tx_Busy),       32'(m_active));
        chk("empty", 32'(FIFO_Empty),    32'(q.size() == 0));
        chk("full",  32'(FIFO_Full),     32'(q.size() == DEPTH));
        chk("level", 32'(Fill_Level),    32'(q.size()));
        chk("ovf",   32'(FIFO_Overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input int d);
        Wr_En   = 1'b1;
        Wr_Data = MAXB'(d);
        tick();
        Wr_En   = 1'b0;
    endtask

    task automatic set_cfg(input int bits, input int par, input int stop2);
        Cfg_Data_Bits = 4'(bits);
        Cfg_Parity    = 2'(par);
        Cfg_Stop_Bits = 1'(stop2);
    endtask

    initial begin
        // Reset state
        Rst = 1'b1;
        run(3);
        Rst = 1'b0;
        run(2);

        // 8N1 0xA5
        set_cfg(8, 0, 0);
        write(8'hA5);
        run(110);

        // 7E2 0x55 with parity switched mid-frame, then 7O2
        set_cfg(7, 1, 1);
        write(8'h55);
        run(30);
        Cfg_Parity = 2'd2;
        run(95);
        write(8'h55);
        run(120);

        // Fill and overflow with CTS low, then drain
        set_cfg(8, 0, 0);
        CTS = 1'b0;
        for (int i = 0; i < 9; i++) write(i * 17 + 3);
        run(3);
        Clr_Overflow = 1'b1;
        tick();
        Clr_Overflow = 1'b0;
        run(2);
        CTS = 1'b1;
        run(820);

        // Back-to-back: three consecutive writes
        Wr_En = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Wr_Data = MAXB'($urandom);
            tick();
        end
        Wr_En = 1'b0;
        run(310);

        // CTS dropped during data bit 2
        write(8'h3C);
        write(8'hC3);
        run(32);
        CTS = 1'b0;
        run(100);
        CTS = 1'b1;
        run(110);

        // Reset during data bit 3
        write(8'h96);
        write(8'h69);
        run(42);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        run(60);

        // Random traffic, formats, flow control and occasional reset
        for (int c = 0; c < 5000; c++) begin
            Wr_En        = ($urandom_range(0, 99) < 3);
            Wr_Data      = MAXB'($urandom);
            CTS          = ($urandom_range(0, 99) < 90);
            Clr_Overflow = ($urandom_range(0, 99) < 2);
            Rst          = ($urandom_range(0, 999) < 1);
            if ($urandom_range(0, 99) < 2)
                set_cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
            tick();
        end
        Wr_En        = 1'b0;
        Clr_Overflow = 1'b0;
        Rst          = 1'b0;
        CTS          = 1'b1;
        run(1300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
